axil_regfile: RTL and testbench

- AXI4-Lite slave exposing NUM_REGS memory-mapped registers starting at BASE_ADDR.
- Generalises the single-register JTAG-to-AXI-lite endpoint:
  - parametrised register count and data width
  - byte strobes
  - per-register read-only (status) mapping
  - decode/slave error responses
  - per-register write strobes
- Sits between the JTAG-AXI master (or interconnect) and DAC control/status logic.

---
 rtl/axil_regfile.sv | 232 +++++++++++++++++++++++
 tb/tb_axil_regfile.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile.sv
// AXI4-Lite register file: NUM_REGS registers of DATA_W bits at BASE_ADDR, byte strobes,
// read-only status mapping and DECERR/SLVERR responses. Independent read and write paths.
module axil_regfile #(
    parameter int                  NUM_REGS  = 8,
    parameter int                  DATA_W    = 32,
    parameter int                  ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = {ADDR_W{1'b0}},
    parameter logic [NUM_REGS-1:0] RO_MASK   = {NUM_REGS{1'b0}}
) (
    input  logic                       s_axi_aclk,
    input  logic                       s_axi_areset,
    input  logic [ADDR_W-1:0]          s_axi_awaddr,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [DATA_W-1:0]          s_axi_wdata,
    input  logic [DATA_W/8-1:0]        s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [ADDR_W-1:0]          s_axi_araddr,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [DATA_W-1:0]          s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic [NUM_REGS-1:0]        reg_wr,
    input  logic [NUM_REGS*DATA_W-1:0] status_in
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(NUM_REGS * STRB_W);

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = (a - BASE_ADDR) >> LSB;
        return off[IDX_W-1:0];
    endfunction

    wstate_t             wstate_r, wstate_nxt_s;
    logic                aw_held_r, w_held_r, aw_held_nxt_s, w_held_nxt_s;
    logic [ADDR_W-1:0]   awaddr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;
    logic                awready_r, wready_r, bvalid_r;
    logic [1:0]          bresp_r;
    logic [NUM_REGS-1:0] reg_wr_r;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic                commit_s, aw_hs_s, w_hs_s, b_hs_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic [STRB_W-1:0]   wr_strb_s;
    logic                wr_hit_s, wr_ok_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic                arready_r, rvalid_r, ar_hs_s, rd_hit_s;
    logic [DATA_W-1:0]   rdata_r, rd_data_s;
    logic [1:0]          rresp_r, rd_resp_s;
    logic [IDX_W-1:0]    rd_idx_s;

    assign aw_hs_s = s_axi_awvalid && awready_r;
    assign w_hs_s  = s_axi_wvalid && wready_r;
    assign b_hs_s  = bvalid_r && s_axi_bready;
    assign ar_hs_s = s_axi_arvalid && arready_r;

    // A channel accepted on the commit edge itself has not reached its latch yet.
    assign wr_addr_s = aw_held_r ? awaddr_r : s_axi_awaddr;
    assign wr_data_s = w_held_r ? wdata_r : s_axi_wdata;
    assign wr_strb_s = w_held_r ? wstrb_r : s_axi_wstrb;
    assign wr_hit_s  = addr_hit(wr_addr_s);
    assign wr_idx_s  = addr_idx(wr_addr_s);
    assign wr_ok_s   = wr_hit_s && !RO_MASK[wr_idx_s];

    // Write FSM next state, channel latch bookkeeping and commit strobe.
    always_comb begin
        wstate_nxt_s  = wstate_r;
        commit_s      = 1'b0;
        aw_held_nxt_s = aw_held_r | aw_hs_s;
        w_held_nxt_s  = w_held_r | w_hs_s;
        case (wstate_r)
            W_IDLE: begin
                if (aw_held_nxt_s && w_held_nxt_s) begin
                    wstate_nxt_s = W_RESP;
                    commit_s     = 1'b1;
                end else begin
                    wstate_nxt_s = W_IDLE;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    wstate_nxt_s  = W_IDLE;
                    aw_held_nxt_s = 1'b0;
                    w_held_nxt_s  = 1'b0;
                end else begin
                    wstate_nxt_s = W_RESP;
                end
            end
            default: begin
                wstate_nxt_s  = W_IDLE;
                aw_held_nxt_s = 1'b0;
                w_held_nxt_s  = 1'b0;
            end
        endcase
    end

    // Write FSM state, channel latches, readies and write response.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            wstate_r  <= W_IDLE;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awaddr_r  <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            wstrb_r   <= {STRB_W{1'b0}};
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            reg_wr_r  <= {NUM_REGS{1'b0}};
        end else begin
            wstate_r  <= wstate_nxt_s;
            aw_held_r <= aw_held_nxt_s;
            w_held_r  <= w_held_nxt_s;
            awready_r <= (wstate_nxt_s == W_IDLE) && !aw_held_nxt_s;
            wready_r  <= (wstate_nxt_s == W_IDLE) && !w_held_nxt_s;
            reg_wr_r  <= {NUM_REGS{1'b0}};
            if (aw_hs_s) begin
                awaddr_r <= s_axi_awaddr;
            end
            if (w_hs_s) begin
                wdata_r <= s_axi_wdata;
                wstrb_r <= s_axi_wstrb;
            end
            if (commit_s) begin
                bvalid_r <= 1'b1;
                if (!wr_hit_s) begin
                    bresp_r <= 2'b11;
                end else if (!wr_ok_s) begin
                    bresp_r <= 2'b10;
                end else begin
                    bresp_r <= 2'b00;
                end
                if (wr_ok_s && (|wr_strb_s)) begin
                    reg_wr_r[wr_idx_s] <= 1'b1;
                end
            end else if (b_hs_s) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Register storage, byte-merged on a successful commit edge only.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (commit_s && wr_ok_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_s[b]) begin
                    regs_r[wr_idx_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
                end
            end
        end
    end

    assign rd_hit_s = addr_hit(s_axi_araddr);
    assign rd_idx_s = addr_idx(s_axi_araddr);

    // Read data mux: stored value, status slice for read-only registers, zero on decode miss.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        rd_resp_s = 2'b11;
        if (!rd_hit_s) begin
            rd_data_s = {DATA_W{1'b0}};
            rd_resp_s = 2'b11;
        end else if (RO_MASK[rd_idx_s]) begin
            rd_data_s = status_in[int'(rd_idx_s)*DATA_W +: DATA_W];
            rd_resp_s = 2'b00;
        end else begin
            rd_data_s = regs_r[rd_idx_s];
            rd_resp_s = 2'b00;
        end
    end

    // Read channel: capture on AR handshake, hold until R handshake.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= {DATA_W{1'b0}};
            rresp_r   <= 2'b00;
        end else if (ar_hs_s) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rdata_r   <= rd_data_s;
            rresp_r   <= rd_resp_s;
        end else if (rvalid_r && s_axi_rready) begin
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
        end else if (!rvalid_r) begin
            arready_r <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = regs_r[g];
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign reg_wr        = reg_wr_r;

endmodule

// File: tb/tb_axil_regfile.sv
// Bench for axil_regfile: directed AXI-Lite transactions against a transaction-level
// register model, with every output compared on each falling edge.
module tb_axil_regfile;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [7:0]  RO   = 8'h80;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic         s_axi_rvalid, s_axi_rready;
    logic [1:0]   s_axi_bresp, s_axi_rresp;
    logic [255:0] regs_out, status_in;
    logic [7:0]   reg_wr;

    always #5 clk = ~clk;

    axil_regfile #(
        .NUM_REGS(8), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE), .RO_MASK(RO)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .regs_out(regs_out), .reg_wr(reg_wr), .status_in(status_in)
    );

    // Transaction-level model of what the slave must present.
    logic [31:0] m_regs [8];
    logic        m_aw_held, m_w_held, m_bvalid, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;
    logic [7:0]  exp_reg_wr;
    logic        alive = 1'b0;
    logic [7:0]  last_reg_wr;
    logic [1:0]  last_bresp, last_rresp;
    logic        last_bvalid;
    logic [31:0] last_rdata;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
        m_aw_held = 1'b0; m_w_held = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
        m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0; exp_reg_wr = 8'h00;
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int i;
        if (!in_range(a)) begin
            d = 32'h0; r = 2'b11;
        end else begin
            i = idx_of(a);
            d = RO[i] ? status_in[i*32 +: 32] : m_regs[i];
            r = 2'b00;
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        if (!in_range(a)) begin
            m_bresp = 2'b11;
        end else begin
            i = idx_of(a);
            if (RO[i]) begin
                m_bresp = 2'b10;
            end else begin
                for (int b = 0; b < 4; b++) if (s[b]) m_regs[i][b*8 +: 8] = d[b*8 +: 8];
                m_bresp = 2'b00;
                if (s != 4'h0) exp_reg_wr = 8'h01 << i;
            end
        end
        m_bvalid = 1'b1;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        chk("regs_out", regs_out, model_flat());
        chk("reg_wr", reg_wr, exp_reg_wr);
        chk("bvalid", s_axi_bvalid, m_bvalid);
        if (m_bvalid) chk("bresp", s_axi_bresp, m_bresp);
        chk("rvalid", s_axi_rvalid, m_rvalid);
        if (m_rvalid) begin
            chk("rdata", s_axi_rdata, m_rdata);
            chk("rresp", s_axi_rresp, m_rresp);
        end
        chk("awready", s_axi_awready, alive && !m_aw_held && !m_bvalid);
        chk("wready", s_axi_wready, alive && !m_w_held && !m_bvalid);
        chk("arready", s_axi_arready, alive && !m_rvalid);
        if (!alive) begin
            chk("rdata_reset", s_axi_rdata, 32'h0);
            chk("bresp_reset", s_axi_bresp, 2'b00);
            chk("rresp_reset", s_axi_rresp, 2'b00);
        end
    end

    // lead > 0: W goes out lead cycles before AW; lead < 0: AW goes out first.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int hold);
        int   aw_start, w_start;
        logic aw_fire, w_fire, aw_done, w_done;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        aw_done  = 1'b0;
        w_done   = 1'b0;
        for (int c = 0; c < 30 && !(aw_done && w_done); c++) begin
            if (!aw_done && c >= aw_start) begin s_axi_awvalid = 1'b1; s_axi_awaddr = a; end
            if (!w_done && c >= w_start) begin
                s_axi_wvalid = 1'b1; s_axi_wdata = d; s_axi_wstrb = s;
            end
            @(negedge clk);
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1;
            if (aw_fire) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; m_aw_held = 1'b1; end
            if (w_fire)  begin s_axi_wvalid = 1'b0;  w_done = 1'b1;  m_w_held = 1'b1;  end
        end
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        if (!(aw_done && w_done)) begin
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            return;
        end
        model_write(a, d, s);
        @(negedge clk);
        last_reg_wr = reg_wr; last_bresp = s_axi_bresp; last_bvalid = s_axi_bvalid;
        @(posedge clk); #1;
        exp_reg_wr = 8'h00;
        repeat (hold) begin @(posedge clk); #1; end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        m_bvalid = 1'b0; m_aw_held = 1'b0; m_w_held = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        logic        fire, done;
        logic [31:0] pd;
        logic [1:0]  pr;
        done = 1'b0;
        s_axi_arvalid = 1'b1; s_axi_araddr = a;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            fire = s_axi_arvalid && s_axi_arready;
            model_read(a, pd, pr);
            @(posedge clk); #1;
            if (fire) begin
                s_axi_arvalid = 1'b0; done = 1'b1;
                m_rvalid = 1'b1; m_rdata = pd; m_rresp = pr;
            end
        end
        chk("rd_handshake", done, 1'b1);
        if (!done) begin s_axi_arvalid = 1'b0; return; end
        @(negedge clk);
        last_rdata = s_axi_rdata; last_rresp = s_axi_rresp;
        @(posedge clk); #1;
        repeat (hold) begin @(posedge clk); #1; end
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        m_rvalid = 1'b0;
    endtask

    initial begin
        logic fire;
        rst = 1'b1;
        s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = 32'h0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        status_in = {32'hCAFE0001, {7{32'hBAD0BAD0}}};
        reset_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 alive = 1'b1;

        do_write(BASE + 32'h4, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("t1_bvalid_lit", last_bvalid, 1'b1);
        chk("t1_bresp_lit", last_bresp, 2'b00);
        chk("t1_reg_wr_lit", last_reg_wr, 8'h02);
        chk("t1_reg1_lit", regs_out[63:32], 32'hDEADBEEF);

        do_write(BASE + 32'h8, 32'hAAAAAAAA, 4'hF, 0, 0);
        do_write(BASE + 32'h8, 32'h12345678, 4'b0101, 3, 5);
        chk("t2_reg2_lit", regs_out[95:64], 32'hAA34AA78);

        do_read(BASE + 32'h4, 2);
        chk("t3_rdata_lit", last_rdata, 32'hDEADBEEF);

        do_write(BASE + 32'h1C, 32'h11112222, 4'hF, 0, 1);
        chk("t4_bresp_lit", last_bresp, 2'b10);
        chk("t4_reg_wr_lit", last_reg_wr, 8'h00);
        do_read(BASE + 32'h1C, 0);
        chk("t4_rdata_lit", last_rdata, 32'hCAFE0001);
        chk("t4_rresp_lit", last_rresp, 2'b00);

        do_write(BASE + 32'h20, 32'h5A5A5A5A, 4'hF, -2, 0);
        chk("t5_decerr_hi_lit", last_bresp, 2'b11);
        do_write(BASE - 32'h4, 32'h5A5A5A5A, 4'hF, 0, 0);
        chk("t5_decerr_lo_lit", last_bresp, 2'b11);
        do_read(BASE + 32'h20, 1);
        chk("t5_rdata_lit", last_rdata, 32'h0);
        chk("t5_rresp_lit", last_rresp, 2'b11);

        do_write(BASE + 32'h18, 32'h600DF00D, 4'hF, -1, 0);
        do_read(BASE + 32'h1A, 0);
        chk("t6_lowbits_lit", last_rdata, 32'h600DF00D);

        do_write(BASE + 32'hC, 32'h01010101, 4'hF, 0, 0);
        fork
            do_write(BASE + 32'hC, 32'h55667788, 4'b1100, 0, 0);
            do_read(BASE + 32'hC, 0);
        join
        chk("t7_prewrite_lit", last_rdata, 32'h01010101);
        chk("t7_reg3_lit", regs_out[127:96], 32'h55660101);

        do_write(BASE + 32'h10, 32'hFFFFFFFF, 4'h0, -1, 0);
        chk("t8_nostrb_regwr_lit", last_reg_wr, 8'h00);
        chk("t8_nostrb_bresp_lit", last_bresp, 2'b00);

        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h77777777; s_axi_wstrb = 4'hF;
        fire = 1'b0;
        for (int c = 0; c < 10 && !fire; c++) begin
            @(negedge clk);
            fire = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1;
            if (fire) begin s_axi_wvalid = 1'b0; m_w_held = 1'b1; end
        end
        chk("t9_w_handshake", fire, 1'b1);
        s_axi_wvalid = 1'b0;
        #2 rst = 1'b1;
        reset_model();
        alive = 1'b0;
        #1;
        chk("t9_abort_regs_lit", regs_out, 256'h0);
        chk("t9_abort_awready_lit", s_axi_awready, 1'b0);
        chk("t9_abort_arready_lit", s_axi_arready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 alive = 1'b1;
        s_axi_awvalid = 1'b1; s_axi_awaddr = BASE + 32'h4;
        fire = 1'b0;
        for (int c = 0; c < 10 && !fire; c++) begin
            @(negedge clk);
            fire = s_axi_awvalid && s_axi_awready;
            @(posedge clk); #1;
            if (fire) begin s_axi_awvalid = 1'b0; m_aw_held = 1'b1; end
        end
        chk("t9_aw_handshake", fire, 1'b1);
        s_axi_awvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t9_no_bvalid_lit", s_axi_bvalid, 1'b0);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
